// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32I datapath: sequences fetch/decode/execute/writeback over a single
// shared memory port and drives every datapath select and strobe, with a memory-wait timeout.
module multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       eq_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_write_o,
    output logic       adr_src_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       reg_write_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [2:0] imm_src_o,
    output logic [1:0] result_src_o,
    output logic       instr_done_o,
    output logic       fault_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_LUI       = 4'd12,
        S_AUIPC     = 4'd13,
        S_FAULT     = 4'd14,
        S_UNUSED    = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // A zero TIMEOUT_CYCLES disables the timeout; keep a 1-bit counter so widths stay legal.
    localparam bit              TO_EN    = (TIMEOUT_CYCLES > 0);
    localparam int              CNT_W    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    state_t            state_q, next_state;
    logic [CNT_W-1:0]  cnt_q;
    logic              done_q;
    logic              timed_out;

    logic       mem_req_c, mem_write_c, adr_src_c, ir_write_c, pc_write_c, reg_write_c;
    logic [1:0] src_a_c, src_b_c, alu_op_c, result_src_c;
    logic [2:0] imm_src_c;

    // Last unacknowledged cycle the counter allows; an ack in this cycle still wins.
    assign timed_out = TO_EN && !mem_ready_i && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= next_state;
            done_q  <= (next_state == S_FETCH) && (state_q != S_FETCH);
            if (next_state != state_q)
                cnt_q <= '0;
            else if (mem_req_c && !mem_ready_i)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        next_state   = state_q;
        mem_req_c    = 1'b0;
        mem_write_c  = 1'b0;
        adr_src_c    = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        src_a_c      = 2'b00;
        src_b_c      = 2'b00;
        alu_op_c     = 2'b00;
        imm_src_c    = 3'b000;
        result_src_c = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_req_c    = 1'b1;
                src_b_c      = 2'b10;
                result_src_c = 2'b10;
                if (mem_ready_i) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    next_state = S_DECODE;
                end else if (timed_out) begin
                    next_state = S_FAULT;
                end
            end
            S_DECODE: begin
                // Branch/JAL target is computed speculatively into ALUOut here.
                src_a_c   = 2'b01;
                src_b_c   = 2'b01;
                imm_src_c = (op_i == OP_JAL) ? 3'b011 : 3'b010;
                case (op_i)
                    OP_LOAD, OP_STORE: next_state = S_MEM_ADDR;
                    OP_R:              next_state = S_EXEC_R;
                    OP_I:              next_state = S_EXEC_I;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_LUI:            next_state = S_LUI;
                    OP_AUIPC:          next_state = S_AUIPC;
                    default:           next_state = S_FAULT;
                endcase
            end
            S_MEM_ADDR: begin
                src_a_c    = 2'b10;
                src_b_c    = 2'b01;
                imm_src_c  = (op_i == OP_STORE) ? 3'b001 : 3'b000;
                next_state = (op_i == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                if (mem_ready_i)    next_state = S_MEM_WB;
                else if (timed_out) next_state = S_FAULT;
            end
            S_MEM_WB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
                next_state   = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src_c   = 1'b1;
                if (mem_ready_i)    next_state = S_FETCH;
                else if (timed_out) next_state = S_FAULT;
            end
            S_EXEC_R: begin
                src_a_c    = 2'b10;
                alu_op_c   = 2'b10;
                next_state = S_ALU_WB;
            end
            S_EXEC_I: begin
                src_a_c    = 2'b10;
                src_b_c    = 2'b01;
                alu_op_c   = 2'b10;
                next_state = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_c = 1'b1;
                next_state  = S_FETCH;
            end
            S_BRANCH: begin
                src_a_c    = 2'b10;
                alu_op_c   = 2'b01;
                pc_write_c = ((funct3_i == 3'b000) && eq_i) || ((funct3_i == 3'b001) && !eq_i);
                next_state = S_FETCH;
            end
            S_JALR: begin
                src_a_c    = 2'b10;
                src_b_c    = 2'b01;
                next_state = S_JAL;
            end
            S_JAL: begin
                // PC takes the target held in ALUOut while the ALU forms the link value.
                pc_write_c = 1'b1;
                src_a_c    = 2'b01;
                src_b_c    = 2'b10;
                next_state = S_ALU_WB;
            end
            S_LUI: begin
                src_a_c    = 2'b11;
                src_b_c    = 2'b01;
                imm_src_c  = 3'b100;
                next_state = S_ALU_WB;
            end
            S_AUIPC: begin
                src_a_c    = 2'b01;
                src_b_c    = 2'b01;
                imm_src_c  = 3'b100;
                next_state = S_ALU_WB;
            end
            S_FAULT:  next_state = S_FAULT;
            default:  next_state = S_FAULT;
        endcase
    end

    // Reset forces every output low immediately, independent of the clock.
    assign mem_req_o    = mem_req_c   & ~rst_i;
    assign mem_write_o  = mem_write_c & ~rst_i;
    assign adr_src_o    = adr_src_c   & ~rst_i;
    assign ir_write_o   = ir_write_c  & ~rst_i;
    assign pc_write_o   = pc_write_c  & ~rst_i;
    assign reg_write_o  = reg_write_c & ~rst_i;
    assign alu_src_a_o  = rst_i ? 2'b00  : src_a_c;
    assign alu_src_b_o  = rst_i ? 2'b00  : src_b_c;
    assign alu_op_o     = rst_i ? 2'b00  : alu_op_c;
    assign imm_src_o    = rst_i ? 3'b000 : imm_src_c;
    assign result_src_o = rst_i ? 2'b00  : result_src_c;
    assign instr_done_o = done_q & ~rst_i;
    assign fault_o      = (state_q == S_FAULT) & ~rst_i;
    assign state_o      = rst_i ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scenario bench for multicycle_ctrl: expected per-cycle output vectors are queued as stimulus is
// applied, observed vectors are captured each cycle, and each scenario compares the two queues.
module tb_multicycle_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [6:0] op_i = 7'd0;
    logic [2:0] funct3_i = 3'd0;
    logic       eq_i = 1'b0;
    logic       mem_ready_i = 1'b0;
    logic       mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o;
    logic [1:0] alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o;
    logic [2:0] imm_src_o;
    logic       instr_done_o, fault_o;
    logic [3:0] state_o;

    int vectors = 0;
    int errors  = 0;
    logic pend_done = 1'b0;

    logic [22:0] exp_q[$];
    logic [22:0] got_q[$];
    string       name_q[$];

    logic [22:0] act;
    assign act = {state_o, mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o,
                  alu_src_a_o, alu_src_b_o, alu_op_o, imm_src_o, result_src_o, instr_done_o, fault_o};

    always #5 clk_i = ~clk_i;

    multicycle_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .funct3_i(funct3_i), .eq_i(eq_i),
        .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_write_o(mem_write_o),
        .adr_src_o(adr_src_o), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
        .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .alu_op_o(alu_op_o), .imm_src_o(imm_src_o), .result_src_o(result_src_o),
        .instr_done_o(instr_done_o), .fault_o(fault_o), .state_o(state_o)
    );

    // Expected output vector for one cycle, taken from the per-state output table.
    function automatic logic [22:0] exp_out(input logic [3:0] st, input logic rdy, input logic eq,
                                            input logic done);
        logic req = 0, wr = 0, adr = 0, irw = 0, pcw = 0, rw = 0, flt = 0;
        logic [1:0] a = 0, b = 0, aop = 0, res = 0;
        logic [2:0] imm = 0;
        case (st)
            4'd0:  begin req = 1; b = 2'b10; res = 2'b10; irw = rdy; pcw = rdy; end
            4'd1:  begin a = 2'b01; b = 2'b01; imm = (op_i == 7'b1101111) ? 3'b011 : 3'b010; end
            4'd2:  begin a = 2'b10; b = 2'b01; imm = (op_i == 7'b0100011) ? 3'b001 : 3'b000; end
            4'd3:  begin req = 1; adr = 1; end
            4'd4:  begin res = 2'b01; rw = 1; end
            4'd5:  begin req = 1; wr = 1; adr = 1; end
            4'd6:  begin a = 2'b10; aop = 2'b10; end
            4'd7:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
            4'd8:  rw = 1;
            4'd9:  begin a = 2'b10; aop = 2'b01; pcw = (funct3_i == 3'b000 && eq) || (funct3_i == 3'b001 && !eq); end
            4'd10: begin pcw = 1; a = 2'b01; b = 2'b10; end
            4'd11: begin a = 2'b10; b = 2'b01; end
            4'd12: begin a = 2'b11; b = 2'b01; imm = 3'b100; end
            4'd13: begin a = 2'b01; b = 2'b01; imm = 3'b100; end
            default: flt = 1;
        endcase
        return {st, req, wr, adr, irw, pcw, rw, a, b, aop, imm, res, done, flt};
    endfunction

    // One clock of stimulus: queue the expectation, capture the DUT away from the edge, advance.
    task automatic step(input logic rdy, input logic eq, input logic [3:0] st, input string nm);
        mem_ready_i = rdy;
        eq_i = eq;
        exp_q.push_back(exp_out(st, rdy, eq, pend_done));
        name_q.push_back(nm);
        pend_done = 1'b0;
        @(negedge clk_i);
        got_q.push_back(act);
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3);
        op_i = op;
        funct3_i = f3;
    endtask

    task automatic test_reset;
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        vectors++;
        if (act !== 23'd0) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", act, 23'd0);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        pend_done = 1'b0;
        step(1'b0, 1'b0, 4'd0, "reset_release_fetch");
        while (exp_q.size() > 0) begin
            logic [22:0] e = exp_q.pop_front();
            logic [22:0] g = got_q.pop_front();
            string n = name_q.pop_front();
            vectors++;
            if (g !== e) begin errors++; $display("FAIL %s: got %h expected %h", n, g, e); end
        end
    endtask

    task automatic test_r_type;
        set_instr(7'b0110011, 3'b000);
        step(1, 0, 4'd0, "r_fetch");
        step(1, 0, 4'd1, "r_decode");
        step(1, 0, 4'd6, "r_exec");
        step(1, 0, 4'd8, "r_wb");
        pend_done = 1'b1;
        while (exp_q.size() > 0) begin
            logic [22:0] e = exp_q.pop_front();
            logic [22:0] g = got_q.pop_front();
            string n = name_q.pop_front();
            vectors++;
            if (g !== e) begin errors++; $display("FAIL %s: got %h expected %h", n, g, e); end
        end
    endtask

    task automatic test_load_wait;
        set_instr(7'b0000011, 3'b010);
        step(1, 0, 4'd0, "lw_fetch");
        step(1, 0, 4'd1, "lw_decode");
        step(1, 0, 4'd2, "lw_addr");
        for (int i = 0; i < 3; i++) step(0, 0, 4'd3, "lw_read_wait");
        step(1, 0, 4'd3, "lw_read_ack");
        step(1, 0, 4'd4, "lw_wb");
        pend_done = 1'b1;
        while (exp_q.size() > 0) begin
            logic [22:0] e = exp_q.pop_front();
            logic [22:0] g = got_q.pop_front();
            string n = name_q.pop_front();
            vectors++;
            if (g !== e) begin errors++; $display("FAIL %s: got %h expected %h", n, g, e); end
        end
    endtask

    task automatic test_store;
        set_instr(7'b0100011, 3'b010);
        step(1, 0, 4'd0, "sw_fetch");
        step(1, 0, 4'd1, "sw_decode");
        step(1, 0, 4'd2, "sw_addr");
        step(1, 0, 4'd5, "sw_write");
        pend_done = 1'b1;
        while (exp_q.size() > 0) begin
            logic [22:0] e = exp_q.pop_front();
            logic [22:0] g = got_q.pop_front();
            string n = name_q.pop_front();
            vectors++;
            if (g !== e) begin errors++; $display("FAIL %s: got %h expected %h", n, g, e); end
        end
    endtask

    task automatic test_branch;
        logic [2:0] f3s[4] = '{3'b000, 3'b001, 3'b100, 3'b001};
        logic       eqs[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            set_instr(7'b1100011, f3s[i]);
            step(1, 0, 4'd0, "br_fetch");
            step(1, 0, 4'd1, "br_decode");
            step(1, eqs[i], 4'd9, "br_resolve");
            pend_done = 1'b1;
        end
        while (exp_q.size() > 0) begin
            logic [22:0] e = exp_q.pop_front();
            logic [22:0] g = got_q.pop_front();
            string n = name_q.pop_front();
            vectors++;
            if (g !== e) begin errors++; $display("FAIL %s: got %h expected %h", n, g, e); end
        end
    endtask

    task automatic test_jumps;
        set_instr(7'b1100111, 3'b000);
        step(1, 0, 4'd0, "jalr_fetch");
        step(1, 0, 4'd1, "jalr_decode");
        step(1, 0, 4'd11, "jalr_target");
        step(1, 0, 4'd10, "jalr_jal");
        step(1, 0, 4'd8, "jalr_link");
        pend_done = 1'b1;
        set_instr(7'b1101111, 3'b000);
        step(1, 0, 4'd0, "jal_fetch");
        step(1, 0, 4'd1, "jal_decode");
        step(1, 0, 4'd10, "jal_jump");
        step(1, 0, 4'd8, "jal_link");
        pend_done = 1'b1;
        while (exp_q.size() > 0) begin
            logic [22:0] e = exp_q.pop_front();
            logic [22:0] g = got_q.pop_front();
            string n = name_q.pop_front();
            vectors++;
            if (g !== e) begin errors++; $display("FAIL %s: got %h expected %h", n, g, e); end
        end
    endtask

    task automatic test_imm_ops;
        logic [6:0] ops[3] = '{7'b0110111, 7'b0010111, 7'b0010011};
        logic [3:0] sts[3] = '{4'd12, 4'd13, 4'd7};
        for (int i = 0; i < 3; i++) begin
            set_instr(ops[i], 3'b000);
            step(1, 0, 4'd0, "imm_fetch");
            step(1, 0, 4'd1, "imm_decode");
            step(1, 0, sts[i], "imm_exec");
            step(1, 0, 4'd8, "imm_wb");
            pend_done = 1'b1;
        end
        while (exp_q.size() > 0) begin
            logic [22:0] e = exp_q.pop_front();
            logic [22:0] g = got_q.pop_front();
            string n = name_q.pop_front();
            vectors++;
            if (g !== e) begin errors++; $display("FAIL %s: got %h expected %h", n, g, e); end
        end
    endtask

    task automatic test_timeout_boundary;
        set_instr(7'b0110011, 3'b000);
        for (int i = 0; i < 3; i++) step(0, 0, 4'd0, "tob_fetch_wait");
        step(1, 0, 4'd0, "tob_fetch_late_ack");
        step(1, 0, 4'd1, "tob_decode");
        step(1, 0, 4'd6, "tob_exec");
        step(1, 0, 4'd8, "tob_wb");
        pend_done = 1'b1;
        set_instr(7'b0000011, 3'b010);
        step(1, 0, 4'd0, "tob_lw_fetch");
        step(1, 0, 4'd1, "tob_lw_decode");
        step(1, 0, 4'd2, "tob_lw_addr");
        for (int i = 0; i < 3; i++) step(0, 0, 4'd3, "tob_lw_wait");
        step(1, 0, 4'd3, "tob_lw_late_ack");
        step(1, 0, 4'd4, "tob_lw_wb");
        pend_done = 1'b1;
        while (exp_q.size() > 0) begin
            logic [22:0] e = exp_q.pop_front();
            logic [22:0] g = got_q.pop_front();
            string n = name_q.pop_front();
            vectors++;
            if (g !== e) begin errors++; $display("FAIL %s: got %h expected %h", n, g, e); end
        end
    endtask

    task automatic test_faults;
        for (int i = 0; i < 4; i++) step(0, 0, 4'd0, "to_fetch_wait");
        for (int i = 0; i < 3; i++) step(1, 0, 4'd14, "to_fault_hold");
        rst_i = 1'b1;
        #1;
        vectors++;
        if (act !== 23'd0) begin
            errors++;
            $display("FAIL fault_reset: got %h expected %h", act, 23'd0);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        pend_done = 1'b0;
        set_instr(7'b1111111, 3'b000);
        step(1, 0, 4'd0, "ill_fetch");
        step(1, 0, 4'd1, "ill_decode");
        step(1, 0, 4'd14, "ill_fault");
        step(1, 0, 4'd14, "ill_fault_hold");
        while (exp_q.size() > 0) begin
            logic [22:0] e = exp_q.pop_front();
            logic [22:0] g = got_q.pop_front();
            string n = name_q.pop_front();
            vectors++;
            if (g !== e) begin errors++; $display("FAIL %s: got %h expected %h", n, g, e); end
        end
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        pend_done = 1'b0;
    endtask

    task automatic test_reset_mid_write;
        set_instr(7'b0100011, 3'b010);
        step(1, 0, 4'd0, "rmw_fetch");
        step(1, 0, 4'd1, "rmw_decode");
        step(1, 0, 4'd2, "rmw_addr");
        step(0, 0, 4'd5, "rmw_write_wait");
        step(0, 0, 4'd5, "rmw_write_wait2");
        rst_i = 1'b1;
        #1;
        vectors++;
        if (act !== 23'd0) begin
            errors++;
            $display("FAIL rmw_async_reset: got %h expected %h", act, 23'd0);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        pend_done = 1'b0;
        step(0, 0, 4'd0, "rmw_after_release");
        step(1, 0, 4'd0, "rmw_refetch");
        while (exp_q.size() > 0) begin
            logic [22:0] e = exp_q.pop_front();
            logic [22:0] g = got_q.pop_front();
            string n = name_q.pop_front();
            vectors++;
            if (g !== e) begin errors++; $display("FAIL %s: got %h expected %h", n, g, e); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got time %0t expected completion", $time);
        $fatal(1, "bench did not complete");
    end

    initial begin
        test_reset();
        test_r_type();
        test_load_wait();
        test_store();
        test_branch();
        test_jumps();
        test_imm_ops();
        test_timeout_boundary();
        test_faults();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
